// File: rtl/note_sequencer.sv
// Song-playback sequencer: walks a {END, REST, note, duration} song memory and holds each note for duration ticks.
// Build option LOOP_SONG_EN: the end of the song restarts playback at address 0 instead of stopping in DONE.
module note_sequencer #(
  parameter int CLK_HZ     = 100000000,
  parameter int TICK_HZ    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DUR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic [ADDR_WIDTH-1:0] song_addr,
  input  logic [15:0]           song_data,
  output logic [3:0]            note,
  output logic                  note_valid,
  output logic                  rest,
  output logic                  beat_pulse,
  output logic                  playing,
  output logic                  done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0]     TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]     TICK_ONE = TICK_W'(1);
  localparam logic [DUR_WIDTH-1:0]  DUR_ONE  = DUR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [TICK_W-1:0]     tick_cnt, tick_d;
  logic [DUR_WIDTH-1:0]  dur_cnt, dur_d;
  logic [3:0]            note_d;
  logic                  note_valid_d, rest_d;
  logic                  advance, song_end;

  // Song entry fields, meaningful only while in WAIT.
  logic                 entry_end, entry_rest;
  logic [3:0]           entry_note;
  logic [DUR_WIDTH-1:0] entry_dur;
  logic                 unused_entry_bits;

  assign entry_end         = song_data[15];
  assign entry_rest        = song_data[14];
  assign entry_note        = song_data[11:8];
  assign entry_dur         = DUR_WIDTH'(song_data[7:0]);
  assign unused_entry_bits = ^song_data[13:12];

  logic tick_wrap, dur_last, last_addr;

  assign tick_wrap = (tick_cnt == TICK_MAX);
  assign dur_last  = (dur_cnt == DUR_ONE);
  assign last_addr = &song_addr;

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state;
    addr_d       = song_addr;
    tick_d       = tick_cnt;
    dur_d        = dur_cnt;
    note_d       = note;
    note_valid_d = note_valid;
    rest_d       = rest;
    advance      = 1'b0;
    song_end     = 1'b0;

    if (start) begin
      // Restart beats pause and a coincident duration expiry.
      state_d      = S_FETCH;
      addr_d       = '0;
      tick_d       = '0;
      dur_d        = '0;
      note_valid_d = 1'b0;
      rest_d       = 1'b0;
    end else begin
      case (state)
        S_FETCH: state_d = S_WAIT;

        S_WAIT: begin
          if (entry_end) begin
            song_end = 1'b1;
          end else if (entry_dur == '0) begin
            advance = 1'b1;
          end else begin
            note_d       = entry_note;
            rest_d       = entry_rest;
            note_valid_d = ~entry_rest;
            dur_d        = entry_dur;
            tick_d       = '0;
            state_d      = S_PLAY;
          end
        end

        S_PLAY: begin
          if (!pause) begin
            if (tick_wrap) begin
              tick_d = '0;
              // dur_cnt stops at 1; the entry ends on this wrap instead.
              if (dur_last) advance = 1'b1;
              else          dur_d   = dur_cnt - DUR_ONE;
            end else begin
              tick_d = tick_cnt + TICK_ONE;
            end
          end
        end

        default: ;
      endcase

      if (advance) begin
        if (last_addr) begin
          song_end = 1'b1;
        end else begin
          addr_d  = song_addr + ADDR_ONE;
          state_d = S_FETCH;
        end
      end

      if (song_end) begin
`ifdef LOOP_SONG_EN
        // An END at address 0 would loop with no audible content, so it stops.
        if (song_addr == '0) begin
          state_d      = S_DONE;
          note_valid_d = 1'b0;
          rest_d       = 1'b0;
        end else begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
`else
        state_d      = S_DONE;
        note_valid_d = 1'b0;
        rest_d       = 1'b0;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      song_addr  <= '0;
      tick_cnt   <= '0;
      dur_cnt    <= '0;
      note       <= '0;
      note_valid <= 1'b0;
      rest       <= 1'b0;
    end else begin
      state      <= state_d;
      song_addr  <= addr_d;
      tick_cnt   <= tick_d;
      dur_cnt    <= dur_d;
      note       <= note_d;
      note_valid <= note_valid_d;
      rest       <= rest_d;
    end
  end

  assign beat_pulse = (state == S_PLAY) && !pause && !start && tick_wrap;
  assign playing    = (state == S_FETCH) || (state == S_WAIT) || (state == S_PLAY);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed song scenarios plus randomized songs, start and pause,
// compared each cycle against a cycle-countdown reference model.
module tb_note_sequencer;

  localparam int CLK_HZ     = 100;
  localparam int TICK_HZ    = 10;
  localparam int ADDR_WIDTH = 4;
  localparam int DUR_WIDTH  = 8;
  localparam int TICK_DIV   = CLK_HZ / TICK_HZ;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset, start, pause;
  logic [ADDR_WIDTH-1:0] song_addr;
  logic [15:0]           song_data;
  logic [3:0]            note;
  logic                  note_valid, rest, beat_pulse, playing, done;

  note_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DUR_WIDTH (DUR_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .song_addr (song_addr),
    .song_data (song_data),
    .note      (note),
    .note_valid(note_valid),
    .rest      (rest),
    .beat_pulse(beat_pulse),
    .playing   (playing),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Song memory with one cycle of read latency.
  logic [15:0] mem [DEPTH];
  always @(posedge clk) song_data <= mem[song_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: song position plus countdowns of fetch-gap cycles and unpaused note cycles left.
  bit m_busy, m_done, m_valid, m_rest;
  int m_idx, m_gap, m_left, m_note;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_valid = 0; m_rest = 0;
    m_idx = 0; m_gap = 0; m_left = 0; m_note = 0;
  endtask

  task automatic model_finish();
    m_busy = 0; m_done = 1; m_valid = 0; m_rest = 0;
  endtask

  task automatic model_next();
    if (m_idx == DEPTH - 1) model_finish();
    else begin
      m_idx++;
      m_gap = 2;
    end
  endtask

  task automatic model_edge(input logic s, input logic p);
    logic [15:0] e;
    if (s) begin
      m_busy = 1; m_done = 0; m_idx = 0; m_gap = 2; m_left = 0; m_valid = 0; m_rest = 0;
    end else if (m_busy) begin
      if (m_left == 0) begin
        m_gap--;
        if (m_gap == 0) begin
          e = mem[m_idx];
          if (e[15]) model_finish();
          else if (e[7:0] == 8'd0) model_next();
          else begin
            m_note  = int'(e[11:8]);
            m_rest  = e[14];
            m_valid = !e[14];
            m_left  = int'(e[7:0]) * TICK_DIV;
          end
        end
      end else if (!p) begin
        m_left--;
        if (m_left == 0) model_next();
      end
    end
  endtask

  // Observation statistics, offsets counted in cycles from the most recent start pulse.
  int cyc = 0, start_cyc = 0;
  int beats, beats_paused, first_valid, first_rest, first_done;
  int first_note [16];
  int obs_addr, obs_valid;
  bit pz = 0;

  task automatic clear_stats();
    beats = 0; beats_paused = 0; first_valid = -1; first_rest = -1; first_done = -1;
    for (int i = 0; i < 16; i++) first_note[i] = -1;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, then advance the model across the rising edge.
  task automatic step(input logic s, input logic p);
    int exp_beat;
    start = s;
    pause = p;
    #1;
    exp_beat = (m_busy && m_left > 0 && !p && !s && (m_left % TICK_DIV) == 1) ? 1 : 0;
    check("song_addr",  song_addr,  m_idx);
    check("note",       note,       m_note);
    check("note_valid", note_valid, m_valid);
    check("rest",       rest,       m_rest);
    check("playing",    playing,    m_busy);
    check("done",       done,       m_done);
    check("beat_pulse", beat_pulse, exp_beat);
    obs_addr  = song_addr;
    obs_valid = note_valid;
    if (beat_pulse) begin
      beats++;
      if (p) beats_paused++;
    end
    if (note_valid && first_valid < 0) first_valid = cyc - start_cyc;
    if (note_valid && first_note[note] < 0) first_note[note] = cyc - start_cyc;
    if (rest && first_rest < 0) first_rest = cyc - start_cyc;
    if (done && first_done < 0) first_done = cyc - start_cyc;
    if (s) begin
      clear_stats();
      start_cyc = cyc;
    end
    model_edge(s, p);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic p);
    repeat (n) step(1'b0, p);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_song_addr",  song_addr,  0);
    check("rst_note",       note,       0);
    check("rst_note_valid", note_valid, 0);
    check("rst_rest",       rest,       0);
    check("rst_beat_pulse", beat_pulse, 0);
    check("rst_playing",    playing,    0);
    check("rst_done",       done,       0);
    model_reset();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_song(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h8000;
    mem[0] = e0;
    mem[1] = e1;
    mem[2] = e2;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h8000;
    clear_stats();
    model_reset();
    do_reset();

    // Pause in IDLE does nothing.
    run(4, 1'b1);

    // Two notes then END.
    load_song(16'h0302, 16'h0701, 16'h8000);
    step(1'b1, 1'b0);
    run(42, 1'b0);
    check("a_note3_first", first_note[3], 3);
    check("a_note7_first", first_note[7], 25);
    check("a_done_first",  first_done,    37);
    check("a_beats",       beats,         3);
    check("a_final_valid", obs_valid,     0);

    // Rest entry, started from DONE.
    load_song(16'h4003, 16'h8000, 16'h8000);
    step(1'b1, 1'b0);
    run(40, 1'b0);
    check("b_rest_first",  first_rest,  3);
    check("b_never_valid", first_valid, -1);
    check("b_beats",       beats,       3);
    check("b_done_first",  first_done,  35);

    // Zero-duration entry is skipped.
    load_song(16'h0500, 16'h0901, 16'h8000);
    step(1'b1, 1'b0);
    run(20, 1'b0);
    check("c_note5_never", first_note[5], -1);
    check("c_note9_first", first_note[9], 5);

    // Pause for 25 cycles in the middle of a two-tick note.
    load_song(16'h0402, 16'h8000, 16'h8000);
    step(1'b1, 1'b0);
    run(7, 1'b0);
    run(25, 1'b1);
    run(30, 1'b0);
    check("d_note4_first", first_note[4], 3);
    check("d_done_first",  first_done,    50);
    check("d_beats",       beats,         2);
    check("d_beats_pause", beats_paused,  0);

    // Restart mid-PLAY while at address 1.
    load_song(16'h0301, 16'h0602, 16'h8000);
    step(1'b1, 1'b0);
    run(17, 1'b0);
    check("e_addr_before", obs_addr, 1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("e_valid_drop", obs_valid, 0);
    check("e_addr_zero",  obs_addr,  0);
    run(5, 1'b0);
    check("e_refirst", first_valid,   3);
    check("e_note3",   first_note[3], 3);
    run(40, 1'b0);

    // Restart on the same edge the note would expire.
    step(1'b1, 1'b0);
    run(11, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("f_expiry_addr",  obs_addr,  0);
    check("f_expiry_valid", obs_valid, 0);
    run(5, 1'b0);
    check("f_refirst", first_note[3], 3);
    run(40, 1'b0);

    // No END anywhere: the last address ends the song.
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0001 | 16'(i << 8);
    step(1'b1, 1'b0);
    run(200, 1'b0);
    check("g_last_note",  first_note[DEPTH-1], 3 + 12 * (DEPTH - 1));
    check("g_done_first", first_done,          3 + 12 * DEPTH - 2);
    check("g_addr_hold",  obs_addr,            DEPTH - 1);

    // Reset in the middle of a note.
    load_song(16'h0302, 16'h0701, 16'h8000);
    step(1'b1, 1'b0);
    run(10, 1'b0);
    do_reset();
    run(3, 1'b0);

    // Randomized songs with random restarts and pause bursts.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [15:0] e;
        e        = '0;
        e[11:8]  = 4'($urandom_range(0, 15));
        e[7:0]   = 8'($urandom_range(0, 3));
        e[14]    = ($urandom_range(0, 3) == 0);
        e[15]    = ($urandom_range(0, 9) == 0);
        mem[i]   = e;
      end
      step(1'b1, pz);
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 14) == 0) pz = !pz;
        step(($urandom_range(0, 199) == 0), pz);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Song-playback stage directly upstream of the VGA note-display controller; it replaces the board switches as the source of the active note lane. It walks a song memory of {note, rest, end, duration} entries and holds each note for its duration in ticks. The display stage consumes `note` as the lane index (lane = note*40 px) and blanks the lane when `note_valid` is low.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
TICK_HZ, 16, duration tick rate; TICK_DIV = CLK_HZ/TICK_HZ, must be >= 2
ADDR_WIDTH, 8, song memory address width; SONG_DEPTH = 2**ADDR_WIDTH
DUR_WIDTH, 8, duration field width in ticks

Ports:
clk  in  1  100 MHz system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begin (or restart) playback from address 0
pause  in  1  level; freezes playback while high
song_addr  out  ADDR_WIDTH  read address to the song memory
song_data  in  16  song entry; valid the cycle after song_addr is presented. Fields: [15] END, [14] REST, [11:8] note, [7:0] duration (DUR_WIDTH = 8)
note  out  4  current lane index 0..15
note_valid  out  1  high while a non-rest note is sounding
rest  out  1  high while a rest entry is playing
beat_pulse  out  1  one-cycle pulse per tick during PLAY
playing  out  1  high in FETCH, WAIT and PLAY
done  out  1  high in DONE

Behaviour:
- Reset values: all outputs 0; state IDLE; tick_cnt = 0; dur_cnt = 0.
- States: IDLE, FETCH, WAIT, PLAY, DONE.
- IDLE: start -> FETCH with song_addr = 0.
- FETCH: address is presented; next cycle -> WAIT.
- WAIT: song_data is valid; decode at the clock edge.
  - END=1: -> DONE; note_valid = 0, rest = 0.
  - duration = 0: entry skipped; song_addr + 1; -> FETCH.
  - Otherwise latch note, set rest = REST and note_valid = ~REST, load dur_cnt = duration, clear tick_cnt; -> PLAY.
- PLAY: tick_cnt counts 0..TICK_DIV-1 and wraps.
  - On wrap: beat_pulse = 1 and dur_cnt decrements.
  - When dur_cnt = 1 at a wrap: -> FETCH with song_addr + 1.
  - Each note therefore lasts exactly duration*TICK_DIV cycles in PLAY.
- Fetch gap: note, note_valid and rest hold their previous values through FETCH/WAIT (2-cycle gap) until the next latch, so the display never flickers between notes.
- Latency: start sampled at edge N -> FETCH in cycle N+1 -> WAIT in N+2 -> note/note_valid valid from cycle N+3.
- Address wrap: if an entry at SONG_DEPTH-1 completes without END, treat it as END -> DONE (no silent wrap).
- Pause high: tick_cnt, dur_cnt, state and outputs freeze; beat_pulse = 0. Pause in IDLE/DONE has no effect. Pause during FETCH/WAIT takes effect on entry to PLAY. Releasing pause resumes from the exact frozen count.
- start in any non-IDLE state, including mid-PLAY, while paused, and in DONE: immediate restart. Clear note_valid/rest, song_addr = 0, -> FETCH. start has priority over pause and over a same-cycle duration expiry.
- DONE: holds, done = 1, until start.
- reset mid-operation: returns to reset values next edge regardless of state.
- Counters: tick_cnt is $clog2(TICK_DIV) bits. dur_cnt is DUR_WIDTH bits and never decrements below 1 in PLAY.

Optional Feature:
LOOP_SONG_EN. When defined:
- END (or address wrap) -> FETCH at address 0 instead of DONE.
- playing stays high and done is never asserted.
- An END entry at address 0 still -> DONE, to avoid an infinite zero-time loop.
When not defined: END -> DONE as above.

Test Plan:
CLK_HZ=100, TICK_HZ=10 (TICK_DIV=10); memory {0x0302, 0x0701, 0x8000}; pulse start at cycle 0 -> note=3, note_valid=1 from cycle 3 for 20 cycles; then note=7 after the 2-cycle gap for 10 cycles; then done=1, note_valid=0.
Entry 0x4003 (rest, 3 ticks) -> rest=1, note_valid=0 for 30 cycles; beat_pulse exactly 3 times.
Entry 0x0500 (duration 0) followed by 0x0901 -> note 5 is never output; note=9 is valid 5 cycles after start.
Pause high for 25 cycles mid-note (duration 2) -> note held; total note time = 20 + 25 cycles; no beat_pulse while paused.
start pulsed mid-PLAY at address 1 -> note_valid drops next cycle; song_addr=0; first note re-output 3 cycles later; start coincident with expiry -> restart wins.
With LOOP_SONG_EN, song {0x0201, 0x8000} -> note=2 repeats every 10+4 cycles; done stays 0. Without it -> done=1 after the first pass.
